// File: rtl/seq_alu_pkg.sv
`default_nettype none
// ============================================================================
// Module      : seq_alu_pkg
// Description : Shared types for the sequential ALU: opcode and A-preprocess
//               encodings plus the control FSM state type.
// Revision    : 1.0 - initial release
// ============================================================================
package seq_alu_pkg;

    // Opcode carried in control[3:2]
    typedef enum logic [1:0] {
        OP_ADD = 2'b00,
        OP_SUB = 2'b01,
        OP_MUL = 2'b10,
        OP_DIV = 2'b11
    } op_e;

    // Operand-A preprocessing carried in control[1:0]
    typedef enum logic [1:0] {
        PRE_A      = 2'b00,
        PRE_CLRMSB = 2'b01,
        PRE_CLRLSB = 2'b10,
        PRE_AND    = 2'b11
    } pre_e;

    // Control FSM states
    typedef enum logic [1:0] {
        ST_IDLE = 2'b00,
        ST_CALC = 2'b01,
        ST_DONE = 2'b10
    } state_e;

endpackage : seq_alu_pkg
`default_nettype wire

// File: rtl/seq_alu_iter.sv
`default_nettype none
// ============================================================================
// Module      : seq_alu_iter
// Description : Iterative MUL/DIV datapath. Shift-add multiply or restoring
//               divide, one result bit per step. Exposes the post-step result
//               combinationally so the caller can capture it on the last step.
// Revision    : 1.0 - initial release
// ============================================================================
module seq_alu_iter
    import seq_alu_pkg::*;
#(
    parameter int W     = 5,
    parameter int CNT_W = $clog2(W + 1)
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             start_i,
    input  logic             is_div_i,
    input  logic [W-1:0]     a_i,
    input  logic [W-1:0]     b_i,
    input  logic             step_i,
    output logic             last_o,
    output logic [2*W-1:0]   res_o,
    output logic [W-1:0]     rem_o
);

    // acc_q  : MUL product accumulator / DIV partial remainder (low W bits)
    // opnd_q : MUL multiplicand (shifts left) / DIV divisor (fixed)
    // sh_q   : MUL multiplier (shifts right) / DIV dividend becoming quotient
    logic [2*W-1:0] acc_q,  acc_d;
    logic [2*W-1:0] opnd_q, opnd_d;
    logic [W-1:0]   sh_q,   sh_d;
    logic           div_q;
    logic [CNT_W-1:0] cnt_q;

    logic [W:0]     w_rshift;
    logic [W+1:0]   w_trial;
    logic           w_fits;

    // One iteration of the selected algorithm, computed from current state
    always_comb begin
        w_rshift = {acc_q[W-1:0], sh_q[W-1]};
        w_trial  = {1'b0, w_rshift} - {2'b00, opnd_q[W-1:0]};
        w_fits   = ~w_trial[W+1];
        acc_d    = acc_q;
        opnd_d   = opnd_q;
        sh_d     = sh_q;
        if (div_q) begin
            // Restoring step: keep the subtraction only when it did not borrow
            acc_d  = {{(W-1){1'b0}}, (w_fits ? w_trial[W:0] : w_rshift)};
            sh_d   = {sh_q[W-2:0], w_fits};
        end else begin
            acc_d  = acc_q + (sh_q[0] ? opnd_q : '0);
            opnd_d = opnd_q << 1;
            sh_d   = sh_q >> 1;
        end
    end

    assign last_o = step_i && (cnt_q == CNT_W'(W - 1));
    assign res_o  = div_q ? {{W{1'b0}}, sh_d} : acc_d;
    assign rem_o  = acc_d[W-1:0];

    // Load operands on start, then advance one bit per step
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            acc_q  <= '0;
            opnd_q <= '0;
            sh_q   <= '0;
            div_q  <= 1'b0;
            cnt_q  <= '0;
        end else if (start_i) begin
            acc_q  <= '0;
            opnd_q <= {{W{1'b0}}, (is_div_i ? b_i : a_i)};
            sh_q   <= is_div_i ? a_i : b_i;
            div_q  <= is_div_i;
            cnt_q  <= '0;
        end else if (step_i) begin
            acc_q  <= acc_d;
            opnd_q <= opnd_d;
            sh_q   <= sh_d;
            cnt_q  <= cnt_q + 1'b1;
        end
    end

endmodule : seq_alu_iter
`default_nettype wire

// File: rtl/seq_alu.sv
`default_nettype none
// ============================================================================
// Module      : seq_alu
// Description : Sequential ALU with valid/ready handshake. ADD/SUB complete in
//               one cycle; MUL/DIV iterate W cycles in seq_alu_iter.
// Revision    : 1.0 - initial release
// ============================================================================
module seq_alu
    import seq_alu_pkg::*;
#(
    parameter int W     = 5,
    parameter int CNT_W = $clog2(W + 1)
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [W-1:0]     a,
    input  logic [W-1:0]     b,
    input  logic [3:0]       control,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [2*W-1:0]   out,
    output logic [W-1:0]     rem,
    output logic             dz
);

    state_e         state_q;
    logic           in_ready_q;
    logic           out_valid_q;
    logic [2*W-1:0] out_q;
    logic [W-1:0]   rem_q;
    logic           dz_q;
    logic           div_q;
    logic           dzp_q;

    op_e            w_op;
    pre_e           w_pre;
    logic [W-1:0]   w_a_pre;
    logic [2*W-1:0] w_sum;
    logic [2*W-1:0] w_diff;
    logic           w_accept;
    logic           w_start;
    logic           w_last;
    logic [2*W-1:0] w_iter_res;
    logic [W-1:0]   w_iter_rem;

    assign w_op  = op_e'(control[3:2]);
    assign w_pre = pre_e'(control[1:0]);

    // Operand A preprocessing ahead of every operation
    always_comb begin
        w_a_pre = a;
        case (w_pre)
            PRE_A:      w_a_pre = a;
            PRE_CLRMSB: w_a_pre = {1'b0, a[W-2:0]};
            PRE_CLRLSB: w_a_pre = {a[W-1:1], 1'b0};
            PRE_AND:    w_a_pre = a & b;
            default:    w_a_pre = a;
        endcase
    end

    assign w_sum    = {{W{1'b0}}, w_a_pre} + {{W{1'b0}}, b};
    assign w_diff   = {{W{1'b0}}, w_a_pre} - {{W{1'b0}}, b};
    assign w_accept = (state_q == ST_IDLE) && in_valid;
    assign w_start  = w_accept && ((w_op == OP_MUL) || (w_op == OP_DIV));

    seq_alu_iter #(
        .W     (W),
        .CNT_W (CNT_W)
    ) u_iter (
        .clk      (clk),
        .rst_n    (rst_n),
        .start_i  (w_start),
        .is_div_i (w_op == OP_DIV),
        .a_i      (w_a_pre),
        .b_i      (b),
        .step_i   (state_q == ST_CALC),
        .last_o   (w_last),
        .res_o    (w_iter_res),
        .rem_o    (w_iter_rem)
    );

    // Handshake FSM with registered ready/valid and result outputs
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q     <= ST_IDLE;
            in_ready_q  <= 1'b1;
            out_valid_q <= 1'b0;
            out_q       <= '0;
            rem_q       <= '0;
            dz_q        <= 1'b0;
            div_q       <= 1'b0;
            dzp_q       <= 1'b0;
        end else begin
            case (state_q)
                ST_IDLE: begin
                    if (w_accept) begin
                        in_ready_q <= 1'b0;
                        case (w_op)
                            OP_ADD, OP_SUB: begin
                                out_q       <= (w_op == OP_ADD) ? w_sum : w_diff;
                                rem_q       <= '0;
                                dz_q        <= 1'b0;
                                out_valid_q <= 1'b1;
                                state_q     <= ST_DONE;
                            end
                            default: begin
                                div_q   <= (w_op == OP_DIV);
                                dzp_q   <= (w_op == OP_DIV) && (b == '0);
                                state_q <= ST_CALC;
                            end
                        endcase
                    end
                end
                ST_CALC: begin
                    if (w_last) begin
                        out_q       <= w_iter_res;
                        rem_q       <= div_q ? w_iter_rem : '0;
                        dz_q        <= dzp_q;
                        out_valid_q <= 1'b1;
                        state_q     <= ST_DONE;
                    end
                end
                ST_DONE: begin
                    if (out_ready) begin
                        out_valid_q <= 1'b0;
                        in_ready_q  <= 1'b1;
                        state_q     <= ST_IDLE;
                    end
                end
                default: begin
                    out_valid_q <= 1'b0;
                    in_ready_q  <= 1'b1;
                    state_q     <= ST_IDLE;
                end
            endcase
        end
    end

    assign in_ready  = in_ready_q;
    assign out_valid = out_valid_q;
    assign out       = out_q;
    assign rem       = rem_q;
    assign dz        = dz_q;

endmodule : seq_alu
`default_nettype wire

// File: tb/tb_seq_alu.sv
`default_nettype none
// ============================================================================
// Module      : tb_seq_alu
// Description : Self-checking bench for seq_alu (W=5) against an arithmetic
//               reference model.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_seq_alu;

    localparam int W = 5;

    logic             clk;
    logic             rst_n;
    logic             in_valid;
    logic             in_ready;
    logic [W-1:0]     a;
    logic [W-1:0]     b;
    logic [3:0]       control;
    logic             out_valid;
    logic             out_ready;
    logic [2*W-1:0]   out;
    logic [W-1:0]     rem;
    logic             dz;

    int n_assert = 0;
    int n_fail   = 0;

    seq_alu #(.W(W)) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .a         (a),
        .b         (b),
        .control   (control),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .out       (out),
        .rem       (rem),
        .dz        (dz)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Reference model straight from the arithmetic rules
    function automatic void model(input logic [3:0] c, input int ai, input int bi,
                                  output int eo, output int er, output int ed, output int el);
        int av;
        int mask2;
        mask2 = (1 << (2 * W)) - 1;
        case (c[1:0])
            2'd0:    av = ai;
            2'd1:    av = ai % (1 << (W - 1));
            2'd2:    av = (ai / 2) * 2;
            default: av = ai & bi;
        endcase
        er = 0; ed = 0; el = 1;
        case (c[3:2])
            2'd0: eo = (av + bi) & mask2;
            2'd1: eo = (av - bi) & mask2;
            2'd2: begin eo = av * bi; el = W + 1; end
            default: begin
                el = W + 1;
                if (bi == 0) begin eo = (1 << W) - 1; er = av; ed = 1; end
                else begin eo = av / bi; er = av % bi; end
            end
        endcase
    endfunction

    // Drives one transaction; returns what was observed, compares nothing
    task automatic run_req(input logic [3:0] c, input logic [W-1:0] av, input logic [W-1:0] bv,
                           input int hold,
                           output logic [2*W-1:0] ro, output logic [W-1:0] rr, output logic rd,
                           output int lat, output bit stable, output bit busy_ok,
                           output bit release_ok, output bit ready_start);
        @(negedge clk);
        ready_start = (in_ready === 1'b1);
        in_valid = 1'b1; control = c; a = av; b = bv;
        @(negedge clk);
        lat = 1; busy_ok = 1'b1;
        while (out_valid !== 1'b1 && lat < 50) begin
            if (in_ready !== 1'b0) busy_ok = 1'b0;
            in_valid = 1'($urandom_range(0, 1));
            a = W'($urandom); b = W'($urandom); control = 4'($urandom);
            @(negedge clk);
            lat++;
        end
        ro = out; rr = rem; rd = dz; stable = 1'b1;
        for (int i = 0; i < hold; i++) begin
            if (in_ready !== 1'b0) busy_ok = 1'b0;
            in_valid = 1'($urandom_range(0, 1));
            a = W'($urandom); b = W'($urandom); control = 4'($urandom);
            @(negedge clk);
            if (out_valid !== 1'b1 || out !== ro || rem !== rr || dz !== rd) stable = 1'b0;
        end
        if (in_ready !== 1'b0) busy_ok = 1'b0;
        in_valid = 1'b0; out_ready = 1'b1;
        @(negedge clk);
        release_ok = (out_valid === 1'b0) && (in_ready === 1'b1);
        out_ready = 1'b0;
    endtask

    logic [2*W-1:0] o_out;
    logic [W-1:0]   o_rem;
    logic           o_dz;
    int             o_lat;
    bit             o_stable, o_busy, o_rel, o_rdy;

    task automatic test_reset();
        rst_n = 1'b0; in_valid = 1'b0; out_ready = 1'b0; a = '0; b = '0; control = '0;
        repeat (3) @(negedge clk);
        n_assert++; if (out_valid !== 1'b0) begin n_fail++; $display("FAIL reset_out_valid got %b want 0", out_valid); end
        n_assert++; if (out !== '0) begin n_fail++; $display("FAIL reset_out got %0d want 0", out); end
        n_assert++; if (rem !== '0) begin n_fail++; $display("FAIL reset_rem got %0d want 0", rem); end
        n_assert++; if (dz !== 1'b0) begin n_fail++; $display("FAIL reset_dz got %b want 0", dz); end
        rst_n = 1'b1;
        @(negedge clk);
        n_assert++; if (in_ready !== 1'b1) begin n_fail++; $display("FAIL reset_in_ready got %b want 1", in_ready); end
    endtask

    task automatic test_add_sub();
        int eo, er, ed, el;
        run_req(4'b0000, 5'd31, 5'd31, 0, o_out, o_rem, o_dz, o_lat, o_stable, o_busy, o_rel, o_rdy);
        n_assert++; if (o_out !== 10'd62) begin n_fail++; $display("FAIL add_out got %0d want 62", o_out); end
        n_assert++; if (o_rem !== '0 || o_dz !== 1'b0) begin n_fail++; $display("FAIL add_remdz got %0d/%b want 0/0", o_rem, o_dz); end
        n_assert++; if (o_lat !== 1) begin n_fail++; $display("FAIL add_latency got %0d want 1", o_lat); end
        run_req(4'b0100, 5'd3, 5'd5, 0, o_out, o_rem, o_dz, o_lat, o_stable, o_busy, o_rel, o_rdy);
        n_assert++; if (o_out !== 10'd1022) begin n_fail++; $display("FAIL sub_out got %0d want 1022", o_out); end
        n_assert++; if (o_lat !== 1) begin n_fail++; $display("FAIL sub_latency got %0d want 1", o_lat); end
        for (int i = 0; i < 8; i++) begin
            logic [3:0] c;
            logic [W-1:0] av, bv;
            c = {1'b0, 1'($urandom), 2'($urandom)}; av = W'($urandom); bv = W'($urandom);
            model(c, int'(av), int'(bv), eo, er, ed, el);
            run_req(c, av, bv, 0, o_out, o_rem, o_dz, o_lat, o_stable, o_busy, o_rel, o_rdy);
            n_assert++;
            if (o_out !== 10'(eo) || o_lat !== el) begin
                n_fail++; $display("FAIL addsub_rand c=%b a=%0d b=%0d got %0d lat %0d want %0d lat %0d", c, av, bv, o_out, o_lat, eo, el);
            end
        end
    endtask

    task automatic test_mul();
        run_req(4'b1000, 5'd31, 5'd31, 0, o_out, o_rem, o_dz, o_lat, o_stable, o_busy, o_rel, o_rdy);
        n_assert++; if (o_out !== 10'd961) begin n_fail++; $display("FAIL mul_out got %0d want 961", o_out); end
        n_assert++; if (o_lat !== 6) begin n_fail++; $display("FAIL mul_latency got %0d want 6", o_lat); end
        n_assert++; if (o_busy !== 1'b1) begin n_fail++; $display("FAIL mul_in_ready_busy got %b want 1", o_busy); end
        n_assert++; if (o_rem !== '0 || o_dz !== 1'b0) begin n_fail++; $display("FAIL mul_remdz got %0d/%b want 0/0", o_rem, o_dz); end
    endtask

    task automatic test_div();
        run_req(4'b1100, 5'd29, 5'd4, 0, o_out, o_rem, o_dz, o_lat, o_stable, o_busy, o_rel, o_rdy);
        n_assert++; if (o_out !== 10'd7 || o_rem !== 5'd1 || o_dz !== 1'b0) begin
            n_fail++; $display("FAIL div_result got %0d r%0d dz%b want 7 r1 dz0", o_out, o_rem, o_dz); end
        n_assert++; if (o_lat !== 6) begin n_fail++; $display("FAIL div_latency got %0d want 6", o_lat); end
        run_req(4'b1100, 5'd29, 5'd0, 0, o_out, o_rem, o_dz, o_lat, o_stable, o_busy, o_rel, o_rdy);
        n_assert++; if (o_out !== 10'd31 || o_rem !== 5'd29 || o_dz !== 1'b1) begin
            n_fail++; $display("FAIL div_by_zero got %0d r%0d dz%b want 31 r29 dz1", o_out, o_rem, o_dz); end
    endtask

    task automatic test_backpressure();
        run_req(4'b1001, 5'd31, 5'd3, 3, o_out, o_rem, o_dz, o_lat, o_stable, o_busy, o_rel, o_rdy);
        n_assert++; if (o_out !== 10'd45) begin n_fail++; $display("FAIL bp_out got %0d want 45", o_out); end
        n_assert++; if (o_stable !== 1'b1) begin n_fail++; $display("FAIL bp_stable got %b want 1", o_stable); end
        n_assert++; if (o_rel !== 1'b1) begin n_fail++; $display("FAIL bp_release got %b want 1", o_rel); end
        n_assert++; if (o_busy !== 1'b1) begin n_fail++; $display("FAIL bp_in_ready_busy got %b want 1", o_busy); end
    endtask

    task automatic test_reset_mid_calc();
        @(negedge clk);
        in_valid = 1'b1; control = 4'b1000; a = 5'd31; b = 5'd31;
        @(negedge clk);
        in_valid = 1'b0;
        @(negedge clk);
        rst_n = 1'b0;
        @(negedge clk);
        n_assert++; if (out_valid !== 1'b0 || out !== '0) begin
            n_fail++; $display("FAIL midreset_out got v%b %0d want v0 0", out_valid, out); end
        n_assert++; if (in_ready !== 1'b1) begin n_fail++; $display("FAIL midreset_in_ready got %b want 1", in_ready); end
        rst_n = 1'b1;
        run_req(4'b1000, 5'd7, 5'd9, 0, o_out, o_rem, o_dz, o_lat, o_stable, o_busy, o_rel, o_rdy);
        n_assert++; if (o_out !== 10'd63 || o_lat !== 6) begin
            n_fail++; $display("FAIL midreset_next got %0d lat %0d want 63 lat 6", o_out, o_lat); end
    endtask

    task automatic test_back_to_back();
        int eo, er, ed, el;
        for (int i = 0; i < 40; i++) begin
            logic [3:0] c;
            logic [W-1:0] av, bv;
            int hold;
            c = 4'($urandom); av = W'($urandom); bv = W'($urandom);
            if (i % 7 == 0) bv = '0;
            hold = $urandom_range(0, 2);
            model(c, int'(av), int'(bv), eo, er, ed, el);
            run_req(c, av, bv, hold, o_out, o_rem, o_dz, o_lat, o_stable, o_busy, o_rel, o_rdy);
            n_assert++;
            if (o_out !== 10'(eo) || o_rem !== W'(er) || o_dz !== 1'(ed)) begin
                n_fail++; $display("FAIL b2b_result c=%b a=%0d b=%0d got %0d r%0d dz%b want %0d r%0d dz%0d",
                                   c, av, bv, o_out, o_rem, o_dz, eo, er, ed);
            end
            n_assert++;
            if (o_lat !== el || o_stable !== 1'b1 || o_busy !== 1'b1 || o_rel !== 1'b1 || o_rdy !== 1'b1) begin
                n_fail++; $display("FAIL b2b_handshake c=%b got lat %0d stable %b busy %b rel %b rdy %b want lat %0d 1 1 1 1",
                                   c, o_lat, o_stable, o_busy, o_rel, o_rdy, el);
            end
        end
    endtask

    initial begin
        test_reset();
        test_add_sub();
        test_mul();
        test_div();
        test_backpressure();
        test_reset_mid_calc();
        test_back_to_back();
        $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
        $finish;
    end

endmodule : tb_seq_alu
`default_nettype wire
